// File: rtl/board_pkg.sv
// Shared board constants and the debounce FSM state encoding.
package board_pkg;

    localparam int CLK_HZ          = 25_000_000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_WAIT = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_WAIT = 2'd3
    } deb_state_t;

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: 2-flop synchroniser, debounce FSM with its stability
// counter, and registered level / press / release outputs.
// Optional auto-repeat on a held switch: define SWITCH_AUTOREPEAT_EN.
module switch_debounce_ch
    import board_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY   = 12_500_000,
    parameter int REPEAT_PERIOD  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_raw,
    output logic       level,
    output logic       press,
    output logic       rel,
    output deb_state_t state
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sw_meta;
    logic             sw_s;
    logic [CNT_W-1:0] cnt;

`ifdef SWITCH_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt;
    logic             rpt_on;
`endif

    // Bring the asynchronous switch into the clock domain; only sw_s is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sw_meta <= sw_raw;
            sw_s    <= sw_meta;
        end
    end

    // Debounce FSM: a level change is accepted only after DEBOUNCE_LIMIT
    // consecutive stable cycles; any bounce back restarts from the held level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_LOW;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
`ifdef SWITCH_AUTOREPEAT_EN
            rpt    <= '0;
            rpt_on <= 1'b0;
`endif
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            unique case (state)
                S_LOW: begin
                    cnt <= '0;
`ifdef SWITCH_AUTOREPEAT_EN
                    rpt    <= '0;
                    rpt_on <= 1'b0;
`endif
                    if (sw_s) state <= S_RISE_WAIT;
                end
                S_RISE_WAIT: begin
                    if (!sw_s) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
`ifdef SWITCH_AUTOREPEAT_EN
                        rpt    <= '0;
                        rpt_on <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    // A falling input wins over a repeat due in the same cycle.
                    if (!sw_s) begin
                        state <= S_FALL_WAIT;
                        cnt   <= '0;
                    end
`ifdef SWITCH_AUTOREPEAT_EN
                    else if (!rpt_on && rpt == RPT_DELAY_LAST) begin
                        press  <= 1'b1;
                        rpt    <= '0;
                        rpt_on <= 1'b1;
                    end else if (rpt_on && rpt == RPT_PERIOD_LAST) begin
                        press <= 1'b1;
                        rpt   <= '0;
                    end else begin
                        rpt <= rpt + 1'b1;
                    end
`endif
                end
                S_FALL_WAIT: begin
                    // rpt is left untouched here so a bounce resumes the repeat timing.
                    if (sw_s) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                        rel   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_LOW;
            endcase
        end
    end

endmodule

// File: rtl/switch_debounce_bank.sv
// Bank of NUM_SW independent debounced switch channels feeding the
// push-button counter. o_State carries each channel's FSM state
// (2 bits per channel, channel 0 in the low bits) for observation.
// Optional auto-repeat on a held switch: define SWITCH_AUTOREPEAT_EN.
module switch_debounce_bank
    import board_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY   = 12_500_000,
    parameter int REPEAT_PERIOD  = 2_500_000
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [NUM_SW-1:0]   i_Switch,
    output logic [NUM_SW-1:0]   o_Switch,
    output logic [NUM_SW-1:0]   o_Press,
    output logic [NUM_SW-1:0]   o_Release,
    output logic [2*NUM_SW-1:0] o_State
);

    // One self-contained debouncer per switch; outputs are concatenated by bit.
    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        deb_state_t ch_state;

        switch_debounce_ch #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk    (i_Clk),
            .rst    (i_Rst),
            .sw_raw (i_Switch[g]),
            .level  (o_Switch[g]),
            .press  (o_Press[g]),
            .rel    (o_Release[g]),
            .state  (ch_state)
        );

        assign o_State[2*g +: 2] = ch_state;
    end

endmodule
